writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the RV64 core: it merges results from the execute unit and the load unit, formats load data, and drives the register file's single write port. Outputs are registered, one write per cycle, so the register file sees a clean write strobe. The stage also produces a retire pulse and a 64-bit instret counter for CSR reads and ecall bookkeeping.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- ex_valid  in  1  execute result valid.
- ex_ready  out  1  stage accepts an execute result this cycle.
- ex_rd  in  5  destination register of the execute result.
- ex_data  in  64  execute result.
- ld_valid  in  1  load response valid; cannot be stalled.
- ld_rd  in  5  load destination register.
- ld_data  in  64  raw aligned doubleword from memory.
- ld_offset  in  3  byte address bits [2:0] of the load.
- ld_funct3  in  3  RISC-V load funct3.
- wb_en  out  1  register-file write enable.
- wb_addr  out  5  register-file write address.
- wb_data  out  64  register-file write data.
- retired  out  1  one-cycle pulse per retired result.
- instret  out  64  count of retired results.

## Operation
- Arbitration: load responses have absolute priority. ex_ready = !ld_valid && !reset (combinational). An execute result is accepted when ex_valid && ex_ready. The producer must hold ex_rd and ex_data stable while ex_valid && !ex_ready.
- Load formatting, using byte offset ld_offset masked to natural alignment:
  - LB(000) / LBU(100): byte at offset, masked to [2:0]; sign-extended for LB, zero-extended for LBU.
  - LH(001) / LHU(101): halfword at offset with bit 0 cleared; sign-extended for LH, zero-extended for LHU.
  - LW(010) / LWU(110): word at offset with bits [1:0] cleared; sign-extended for LW, zero-extended for LWU.
  - LD(011): full 64 bits; offset ignored.
  - 111: data = 0; the write still occurs.
- rd = 0: wb_en stays 0, but retired still pulses and instret still increments.
- instret: increments by 1 per retired result and wraps from 2^64−1 to 0.

## Timing
- Latency is 1 cycle. A beat accepted in cycle N appears on wb_en/wb_addr/wb_data/retired in cycle N+1. At most one beat per cycle.
- wb_en and retired are single-cycle pulses unless another beat is accepted in the next cycle.
- instret reflects the beat in the same cycle that retired is high: registered together.
- Simultaneous ld_valid and ex_valid: the load is written, the execute beat is stalled and written in a later cycle. It is never dropped or duplicated.
- Reset values: wb_en=0, wb_addr=0, wb_data=0, retired=0, instret=0, ex_ready=0.
- Reset mid-operation: any beat presented during reset is discarded. In the cycle after reset deasserts, outputs remain at reset values.

## Structure
- Shared core package holds:
  - the load funct3 enum (LB, LH, LW, LD, LBU, LHU, LWU);
  - the XLEN constant;
  - the ABI register-index constants (A0..A7).
- One sub-module: load_align, a combinational extractor from (ld_data, ld_offset, ld_funct3) to a 64-bit formatted value.
- The top level holds:
  - the arbiter;
  - the output registers;
  - the instret counter.

## Test plan
- ALU only: ex_valid, ex_rd=5, ex_data=0x1234 → next cycle wb_en=1, wb_addr=5, wb_data=0x1234, retired=1, instret=1.
- LB sign extension: ld_data=0x80_00_00_00_00_00_00_00, offset=7, funct3=000, rd=10 → wb_data=0xFFFF_FFFF_FFFF_FF80. Same inputs with LBU → 0x80.
- LW/LWU alignment: ld_data=0x8765_4321_0000_0000, offset=5, LW → 0xFFFF_FFFF_8765_4321 (offset masked to 4). LWU → 0x8765_4321.
- Collision: ld_valid and ex_valid in the same cycle → ex_ready=0, load written first, ALU written the following cycle, instret +2 total.
- rd=0: ex_rd=0 → wb_en=0, retired=1, instret incremented.
- Reset mid-stream: reset asserted while ex_valid is high → no write, all outputs at reset values, instret=0. After release, the held beat is accepted normally.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared core definitions for the writeback stage:
// datapath width, load funct3 encodings, ABI register indices.
package writeback_stage_pkg;

  localparam int XLEN_C = 64;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } ld_funct3_e;

  localparam logic [4:0] A0 = 5'd10;
  localparam logic [4:0] A1 = 5'd11;
  localparam logic [4:0] A2 = 5'd12;
  localparam logic [4:0] A3 = 5'd13;
  localparam logic [4:0] A4 = 5'd14;
  localparam logic [4:0] A5 = 5'd15;
  localparam logic [4:0] A6 = 5'd16;
  localparam logic [4:0] A7 = 5'd17;

  function automatic logic rd_writes(input logic [4:0] rd);
    return rd != 5'd0;
  endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load data extractor: picks the naturally aligned byte/half/word
// out of the raw doubleword and sign- or zero-extends it.
module load_align
  import writeback_stage_pkg::*;
(
  input  logic [XLEN_C-1:0] i_data,
  input  logic [2:0]        i_offset,
  input  logic [2:0]        i_funct3,
  output logic [XLEN_C-1:0] o_data
);

  logic [XLEN_C-1:0] w_sh_b;
  logic [XLEN_C-1:0] w_sh_h;
  logic [XLEN_C-1:0] w_sh_w;

  // offset low bits are dropped to force natural alignment
  assign w_sh_b = i_data >> {i_offset, 3'b000};
  assign w_sh_h = i_data >> {i_offset[2:1], 4'b0000};
  assign w_sh_w = i_data >> {i_offset[2], 5'b00000};

  always_comb begin
    o_data = '0;
    unique case (i_funct3)
      LB:  o_data = {{56{w_sh_b[7]}}, w_sh_b[7:0]};
      LH:  o_data = {{48{w_sh_h[15]}}, w_sh_h[15:0]};
      LW:  o_data = {{32{w_sh_w[31]}}, w_sh_w[31:0]};
      LD:  o_data = i_data;
      LBU: o_data = {56'd0, w_sh_b[7:0]};
      LHU: o_data = {48'd0, w_sh_h[15:0]};
      LWU: o_data = {32'd0, w_sh_w[31:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: arbitrates load vs execute results,
// drives the register-file write port and the instret counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = XLEN_C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      ld_offset,
  input  logic [2:0]      ld_funct3,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            retired,
  output logic [63:0]     instret
);

  logic            w_ex_acc;
  logic            w_beat;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_ld_fmt;
  logic [XLEN-1:0] w_data;

  logic            r_wb_en;
  logic [4:0]      r_wb_addr;
  logic [XLEN-1:0] r_wb_data;
  logic            r_retired;
  logic [63:0]     r_instret;

  load_align u_align (
    .i_data   (ld_data),
    .i_offset (ld_offset),
    .i_funct3 (ld_funct3),
    .o_data   (w_ld_fmt)
  );

  // loads cannot be back-pressured, so they always win
  assign ex_ready = !ld_valid && !reset;
  assign w_ex_acc = ex_valid && ex_ready;
  assign w_beat   = ld_valid || w_ex_acc;
  assign w_rd     = ld_valid ? ld_rd : ex_rd;
  assign w_data   = ld_valid ? w_ld_fmt : ex_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_retired <= 1'b0;
      r_instret <= '0;
    end else begin
      r_wb_en   <= w_beat && rd_writes(w_rd);
      r_retired <= w_beat;
      if (w_beat) begin
        r_wb_addr <= w_rd;
        r_wb_data <= w_data;
        r_instret <= r_instret + 64'd1;
      end
    end
  end

  assign wb_en   = r_wb_en;
  assign wb_addr = r_wb_addr;
  assign wb_data = r_wb_data;
  assign retired = r_retired;
  assign instret = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed + randomized scoreboard bench for writeback_stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [63:0] ex_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic [2:0]  ld_offset;
  logic [2:0]  ld_funct3;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        retired;
  logic [63:0] instret;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  logic [63:0] m_instret;
  logic [63:0] ld_exp;
  logic        last_acc;
  int          checks = 0;
  int          failures = 0;

  writeback_stage dut (
    .clk       (clk),
    .reset     (reset),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_rd     (ex_rd),
    .ex_data   (ex_data),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_offset (ld_offset),
    .ld_funct3 (ld_funct3),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .retired   (retired),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_load(
    input logic [63:0] d,
    input logic [2:0] off,
    input logic [2:0] f3
  );
    int size;
    int base;
    logic [63:0] v;
    if (f3 == 3'b111) return 64'd0;
    size = 1 << f3[1:0];
    base = int'(off) & ~(size - 1);
    v = 64'd0;
    for (int i = 0; i < size; i++)
      v |= ((d >> (8 * (base + i))) & 64'hFF) << (8 * i);
    if (!f3[2] && size < 8 && v[8*size-1])
      v |= ~64'd0 << (8 * size);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // predict acceptance, clock once, compare outputs against scoreboard
  task automatic cycle();
    exp_t e;
    #1;
    chk("ex_ready", {63'd0, ex_ready}, {63'd0, !ld_valid && !reset});
    last_acc = 1'b0;
    if (!reset) begin
      if (ld_valid)
        q.push_back('{ld_rd != 0, ld_rd, ld_exp});
      else if (ex_valid) begin
        q.push_back('{ex_rd != 0, ex_rd, ex_data});
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      m_instret = 64'd0;
      chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
      chk("rst_wb_addr", {59'd0, wb_addr}, 64'd0);
      chk("rst_wb_data", wb_data, 64'd0);
      chk("rst_retired", {63'd0, retired}, 64'd0);
      chk("rst_instret", instret, 64'd0);
    end else if (q.size() != 0) begin
      e = q.pop_front();
      m_instret++;
      chk("retired", {63'd0, retired}, 64'd1);
      chk("wb_en", {63'd0, wb_en}, {63'd0, e.en});
      chk("wb_addr", {59'd0, wb_addr}, {59'd0, e.addr});
      chk("wb_data", wb_data, e.data);
      chk("instret", instret, m_instret);
    end else begin
      chk("idle_retired", {63'd0, retired}, 64'd0);
      chk("idle_wb_en", {63'd0, wb_en}, 64'd0);
      chk("idle_instret", instret, m_instret);
    end
  endtask

  task automatic set_ld(input logic [4:0] rd, input logic [63:0] d,
                        input logic [2:0] off, input logic [2:0] f3,
                        input logic [63:0] exp);
    ld_valid = 1'b1;
    ld_rd = rd;
    ld_data = d;
    ld_offset = off;
    ld_funct3 = f3;
    ld_exp = exp;
  endtask

  initial begin
    m_instret = 64'd0;
    reset = 1'b1;
    ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    ld_offset = '0; ld_funct3 = '0; ld_exp = '0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // ALU only
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 64'h1234;
    cycle();
    ex_valid = 1'b0;
    cycle();

    // LB / LBU sign vs zero extension
    set_ld(5'd10, 64'h8000_0000_0000_0000, 3'd7, 3'b000,
           64'hFFFF_FFFF_FFFF_FF80);
    cycle();
    set_ld(5'd10, 64'h8000_0000_0000_0000, 3'd7, 3'b100, 64'h80);
    cycle();
    // LW / LWU with misaligned offset masked to 4
    set_ld(5'd11, 64'h8765_4321_0000_0000, 3'd5, 3'b010,
           64'hFFFF_FFFF_8765_4321);
    cycle();
    set_ld(5'd11, 64'h8765_4321_0000_0000, 3'd5, 3'b110,
           64'h0000_0000_8765_4321);
    cycle();
    // LH at offset 3 -> halfword at 2; LD ignores offset; 111 -> 0
    set_ld(5'd12, 64'h0000_0000_9ABC_0000, 3'd3, 3'b001,
           64'hFFFF_FFFF_FFFF_9ABC);
    cycle();
    set_ld(5'd13, 64'hDEAD_BEEF_CAFE_F00D, 3'd6, 3'b011,
           64'hDEAD_BEEF_CAFE_F00D);
    cycle();
    set_ld(5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 3'b111, 64'd0);
    cycle();
    ld_valid = 1'b0;
    cycle();

    // collision: load wins, execute beat follows next cycle
    set_ld(5'd15, 64'h0000_0000_0000_007F, 3'd0, 3'b000, 64'h7F);
    ex_valid = 1'b1; ex_rd = 5'd16; ex_data = 64'hABCD;
    cycle();
    ld_valid = 1'b0;
    cycle();
    ex_valid = 1'b0;
    cycle();

    // rd = 0 retires without writing
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 64'h55;
    cycle();
    ex_valid = 1'b0;
    cycle();

    // reset with a beat pending; beat is held and accepted after release
    ex_valid = 1'b1; ex_rd = 5'd17; ex_data = 64'h77;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    ex_valid = 1'b0;
    cycle();

    // random mix, execute beat held stable while stalled
    for (int i = 0; i < 60; i++) begin
      logic [63:0] d;
      logic [2:0] off;
      logic [2:0] f3;
      if (!ex_valid || last_acc) begin
        ex_valid = 1'($urandom_range(0, 1));
        ex_rd = 5'($urandom);
        ex_data = {32'($urandom), 32'($urandom)};
      end
      d = {32'($urandom), 32'($urandom)};
      off = 3'($urandom);
      f3 = 3'($urandom);
      if ($urandom_range(0, 2) == 0)
        set_ld(5'($urandom), d, off, f3, model_load(d, off, f3));
      else
        ld_valid = 1'b0;
      cycle();
    end
    ld_valid = 1'b0;
    ex_valid = 1'b0;
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
